// File: rtl/operand_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_unit
// Description : 6502 opcode/operand fetcher with full NMOS addressing-mode
//               decode and effective-address resolution. Define
//               FETCH_JMP_IND_BUG_EN to reproduce the JMP (ind) page-wrap bug.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_unit #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    REG_WIDTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic                  phi1,
    input  logic                  reset,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [REG_WIDTH-1:0]  mem_data,
    input  logic [REG_WIDTH-1:0]  x_in,
    input  logic [REG_WIDTH-1:0]  y_in,
    input  logic                  instr_ack,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_val,
    output logic                  instr_valid,
    output logic [REG_WIDTH-1:0]  opcode,
    output logic [3:0]            add_mode,
    output logic [REG_WIDTH-1:0]  imm,
    output logic [ADDR_WIDTH-1:0] eff_addr,
    output logic                  page_cross,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam int c_hi_w = ADDR_WIDTH - REG_WIDTH;
    localparam logic [c_hi_w-1:0]     c_hi_zero  = '0;
    localparam logic [REG_WIDTH-1:0]  c_reg_one  = REG_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

    // Read states are encoded below CALC so "is a read state" is a compare.
    localparam logic [3:0] c_st_vec_lo = 4'd0;
    localparam logic [3:0] c_st_vec_hi = 4'd1;
    localparam logic [3:0] c_st_opc    = 4'd2;
    localparam logic [3:0] c_st_op1    = 4'd3;
    localparam logic [3:0] c_st_op2    = 4'd4;
    localparam logic [3:0] c_st_ptr_lo = 4'd5;
    localparam logic [3:0] c_st_ptr_hi = 4'd6;
    localparam logic [3:0] c_st_calc   = 4'd7;
    localparam logic [3:0] c_st_hold   = 4'd8;

    localparam logic [3:0] c_m_impl  = 4'd0;
    localparam logic [3:0] c_m_imm   = 4'd1;
    localparam logic [3:0] c_m_zpg   = 4'd2;
    localparam logic [3:0] c_m_zpg_x = 4'd3;
    localparam logic [3:0] c_m_zpg_y = 4'd4;
    localparam logic [3:0] c_m_abs   = 4'd5;
    localparam logic [3:0] c_m_abs_x = 4'd6;
    localparam logic [3:0] c_m_abs_y = 4'd7;
    localparam logic [3:0] c_m_x_ind = 4'd8;
    localparam logic [3:0] c_m_ind_y = 4'd9;
    localparam logic [3:0] c_m_ind   = 4'd10;
    localparam logic [3:0] c_m_rel   = 4'd11;

    logic [3:0]            r_state, w_state_n, r_mode, w_mode_n, w_dec_mode;
    logic                  r_mem_rd, r_instr_valid, r_page_cross;
    logic [ADDR_WIDTH-1:0] r_mem_addr, r_pc, w_pc_n, r_eff_addr, r_instr_pc;
    logic [REG_WIDTH-1:0]  r_opcode, r_op1, r_op2, w_op1_n, w_op2_n;
    logic [REG_WIDTH-1:0]  r_ptr_lo, r_ptr_hi, w_idx;
    logic                  w_done, w_read_n, w_two_byte, w_calc_cross;
    logic [ADDR_WIDTH-1:0] w_ptr_addr, w_ptr_hi_addr, w_next_addr, w_calc_addr, w_rel;
    logic [REG_WIDTH:0]    w_lo_sum, w_ind_sum;

    function automatic logic [3:0] f_decode(input logic [REG_WIDTH-1:0] op);
        logic [3:0] m;
        if (op[0]) begin
            // cc=01 column; undocumented cc=11 opcodes share it
            case (op[4:2])
                3'd0:    m = c_m_x_ind;
                3'd1:    m = c_m_zpg;
                3'd2:    m = c_m_imm;
                3'd3:    m = c_m_abs;
                3'd4:    m = c_m_ind_y;
                3'd5:    m = c_m_zpg_x;
                3'd6:    m = c_m_abs_y;
                default: m = c_m_abs_x;
            endcase
        end else begin
            case (op[4:2])
                3'd1:    m = c_m_zpg;
                3'd3:    m = c_m_abs;
                3'd5:    m = c_m_zpg_x;
                3'd7:    m = c_m_abs_x;
                default: m = c_m_impl;
            endcase
            if (op[4:0] == 5'b10000) m = c_m_rel;
            case (op[7:0])
                8'h20, 8'h4C:               m = c_m_abs;
                8'h6C:                      m = c_m_ind;
                8'hA0, 8'hA2, 8'hC0, 8'hE0: m = c_m_imm;
                8'h96, 8'hB6:               m = c_m_zpg_y;
                8'hBE:                      m = c_m_abs_y;
                default:                    m = m;
            endcase
        end
        return m;
    endfunction

    always_comb begin
        w_done     = r_mem_rd && mem_ready;
        w_dec_mode = f_decode(mem_data);
        w_two_byte = (r_mode == c_m_abs) || (r_mode == c_m_abs_x) ||
                     (r_mode == c_m_abs_y) || (r_mode == c_m_ind);
        w_state_n  = r_state;
        w_pc_n     = r_pc;
        w_op1_n    = r_op1;
        w_op2_n    = r_op2;
        w_mode_n   = r_mode;
        case (r_state)
            c_st_vec_lo: if (w_done) w_state_n = c_st_vec_hi;
            c_st_vec_hi: if (w_done) begin
                w_pc_n    = {mem_data, r_ptr_lo};
                w_state_n = c_st_opc;
            end
            c_st_opc: if (w_done) begin
                w_pc_n    = r_pc + c_addr_one;
                w_mode_n  = w_dec_mode;
                w_op1_n   = '0;
                w_op2_n   = '0;
                w_state_n = (w_dec_mode == c_m_impl) ? c_st_calc : c_st_op1;
            end
            c_st_op1: if (w_done) begin
                w_pc_n  = r_pc + c_addr_one;
                w_op1_n = mem_data;
                if (w_two_byte)
                    w_state_n = c_st_op2;
                else if ((r_mode == c_m_x_ind) || (r_mode == c_m_ind_y))
                    w_state_n = c_st_ptr_lo;
                else
                    w_state_n = c_st_calc;
            end
            c_st_op2: if (w_done) begin
                w_pc_n    = r_pc + c_addr_one;
                w_op2_n   = mem_data;
                w_state_n = (r_mode == c_m_ind) ? c_st_ptr_lo : c_st_calc;
            end
            c_st_ptr_lo: if (w_done) w_state_n = c_st_ptr_hi;
            c_st_ptr_hi: if (w_done) w_state_n = c_st_calc;
            c_st_calc:   w_state_n = c_st_hold;
            c_st_hold:   if (instr_ack) w_state_n = c_st_opc;
            default:     w_state_n = c_st_vec_lo;
        endcase

        case (w_mode_n)
            c_m_x_ind: w_ptr_addr = {c_hi_zero, w_op1_n + x_in};
            c_m_ind_y: w_ptr_addr = {c_hi_zero, w_op1_n};
            default:   w_ptr_addr = {w_op2_n, w_op1_n};
        endcase

        // r_mem_addr still holds the low pointer address when leaving PTR_LO
        if (r_mode == c_m_ind) begin
`ifdef FETCH_JMP_IND_BUG_EN
            w_ptr_hi_addr = {r_mem_addr[ADDR_WIDTH-1:REG_WIDTH],
                             r_mem_addr[REG_WIDTH-1:0] + c_reg_one};
`else
            w_ptr_hi_addr = r_mem_addr + c_addr_one;
`endif
        end else begin
            w_ptr_hi_addr = {c_hi_zero, r_mem_addr[REG_WIDTH-1:0] + c_reg_one};
        end

        case (w_state_n)
            c_st_vec_lo: w_next_addr = RESET_VECTOR;
            c_st_vec_hi: w_next_addr = RESET_VECTOR + c_addr_one;
            c_st_ptr_lo: w_next_addr = w_ptr_addr;
            c_st_ptr_hi: w_next_addr = w_ptr_hi_addr;
            default:     w_next_addr = w_pc_n;
        endcase
        w_read_n = (w_state_n <= c_st_ptr_hi);

        w_idx = ((r_mode == c_m_zpg_y) || (r_mode == c_m_abs_y)) ? y_in : x_in;
        w_lo_sum  = {1'b0, r_op1} + {1'b0, w_idx};
        w_ind_sum = {1'b0, r_ptr_lo} + {1'b0, y_in};
        w_rel     = r_pc + {{c_hi_w{r_op1[REG_WIDTH-1]}}, r_op1};
        w_calc_addr  = '0;
        w_calc_cross = 1'b0;
        case (r_mode)
            c_m_zpg:              w_calc_addr = {c_hi_zero, r_op1};
            c_m_zpg_x, c_m_zpg_y: w_calc_addr = {c_hi_zero, w_lo_sum[REG_WIDTH-1:0]};
            c_m_abs:              w_calc_addr = {r_op2, r_op1};
            c_m_abs_x, c_m_abs_y: begin
                w_calc_addr  = {r_op2 + REG_WIDTH'(w_lo_sum[REG_WIDTH]),
                                w_lo_sum[REG_WIDTH-1:0]};
                w_calc_cross = w_lo_sum[REG_WIDTH];
            end
            c_m_x_ind, c_m_ind:   w_calc_addr = {r_ptr_hi, r_ptr_lo};
            c_m_ind_y: begin
                w_calc_addr  = {r_ptr_hi + REG_WIDTH'(w_ind_sum[REG_WIDTH]),
                                w_ind_sum[REG_WIDTH-1:0]};
                w_calc_cross = w_ind_sum[REG_WIDTH];
            end
            c_m_rel: begin
                w_calc_addr  = w_rel;
                w_calc_cross = w_rel[ADDR_WIDTH-1:REG_WIDTH] != r_pc[ADDR_WIDTH-1:REG_WIDTH];
            end
            default: w_calc_addr = '0;
        endcase
    end

    always_ff @(posedge phi1) begin
        if (reset) begin
            r_state       <= c_st_vec_lo;
            r_mode        <= c_m_impl;
            r_mem_rd      <= 1'b0;
            r_mem_addr    <= '0;
            r_instr_valid <= 1'b0;
            r_opcode      <= '0;
            r_op1         <= '0;
            r_op2         <= '0;
            r_ptr_lo      <= '0;
            r_ptr_hi      <= '0;
            r_eff_addr    <= '0;
            r_page_cross  <= 1'b0;
            r_instr_pc    <= '0;
            r_pc          <= '0;
        end else if (pc_load && (r_state != c_st_vec_lo) && (r_state != c_st_vec_hi)) begin
            // Abandon any read; OPC re-issues with mem_rd low for this cycle
            r_pc          <= pc_load_val;
            r_instr_valid <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_state       <= c_st_opc;
        end else begin
            r_state       <= w_state_n;
            r_pc          <= w_pc_n;
            r_op1         <= w_op1_n;
            r_op2         <= w_op2_n;
            r_mode        <= w_mode_n;
            r_instr_valid <= (w_state_n == c_st_hold);
            if (!(r_mem_rd && !mem_ready)) begin
                r_mem_rd <= w_read_n;
                if (w_read_n) r_mem_addr <= w_next_addr;
            end
            if (w_done) begin
                case (r_state)
                    c_st_vec_lo, c_st_ptr_lo: r_ptr_lo <= mem_data;
                    c_st_ptr_hi:              r_ptr_hi <= mem_data;
                    c_st_opc: begin
                        r_opcode   <= mem_data;
                        r_instr_pc <= r_mem_addr;
                    end
                    default: ;
                endcase
            end
            if (r_state == c_st_calc) begin
                r_eff_addr   <= w_calc_addr;
                r_page_cross <= w_calc_cross;
            end
        end
    end

    assign mem_rd      = r_mem_rd;
    assign mem_addr    = r_mem_addr;
    assign instr_valid = r_instr_valid;
    assign opcode      = r_opcode;
    assign add_mode    = r_mode;
    assign imm         = r_op1;
    assign eff_addr    = r_eff_addr;
    assign page_cross  = r_page_cross;
    assign instr_pc    = r_instr_pc;
    assign pc          = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch_unit
// Description : Directed self-checking bench for operand_fetch_unit with a
//               64 KiB byte memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch_unit;

    logic        phi1 = 1'b0;
    logic        reset, mem_ready, instr_ack, pc_load;
    logic        mem_rd, instr_valid, page_cross;
    logic [15:0] mem_addr, pc_load_val, eff_addr, instr_pc, pc;
    logic [7:0]  mem_data, x_in, y_in, opcode, imm;
    logic [3:0]  add_mode;
    logic [7:0]  r_mem [0:65535];
    logic [15:0] r_exp_ind;
    int          checks = 0;
    int          errors = 0;
    int          lat;

    always #5 phi1 = ~phi1;
    assign mem_data = r_mem[mem_addr];

    operand_fetch_unit dut (
        .phi1(phi1), .reset(reset), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_data(mem_data), .x_in(x_in), .y_in(y_in),
        .instr_ack(instr_ack), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .instr_valid(instr_valid), .opcode(opcode), .add_mode(add_mode),
        .imm(imm), .eff_addr(eff_addr), .page_cross(page_cross),
        .instr_pc(instr_pc), .pc(pc)
    );

    task automatic tick;
        @(posedge phi1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reset, walk the vector fetch, and return right after OPC is entered.
    task automatic boot(input logic [15:0] start);
        r_mem[16'hFFFC] = start[7:0];
        r_mem[16'hFFFD] = start[15:8];
        reset = 1'b1; mem_ready = 1'b1; instr_ack = 1'b0; pc_load = 1'b0;
        tick; tick;
        chk("rst_outputs", {instr_valid, mem_rd, page_cross}, 3'b000);
        chk("rst_pc", pc, 16'h0000);
        reset = 1'b0;
        tick; chk("vec_lo_rd", {mem_rd, mem_addr}, {1'b1, 16'hFFFC});
        tick; chk("vec_hi_rd", {mem_rd, mem_addr}, {1'b1, 16'hFFFD});
        tick; chk("boot_pc", pc, start);
        chk("opc_rd", {mem_rd, mem_addr}, {1'b1, start});
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (instr_valid !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
    endtask

    initial begin
`ifdef FETCH_JMP_IND_BUG_EN
        r_exp_ind = 16'h5040;
`else
        r_exp_ind = 16'h6040;
`endif
        for (int i = 0; i < 65536; i++) r_mem[i] = 8'h00;
        reset = 1'b1; mem_ready = 1'b1; instr_ack = 1'b0; pc_load = 1'b0;
        pc_load_val = 16'h0000; x_in = 8'h00; y_in = 8'h00;

        // LDA abs,X with low-byte carry
        r_mem[16'h8000] = 8'hBD; r_mem[16'h8001] = 8'h0F; r_mem[16'h8002] = 8'h12;
        x_in = 8'hF1;
        boot(16'h8000);
        wait_valid(lat);
        chk("absx_lat", lat, 4);
        chk("absx_mode", add_mode, 4'd6);
        chk("absx_ea", {page_cross, eff_addr}, {1'b1, 16'h1300});
        chk("absx_pc", {instr_pc, pc}, {16'h8000, 16'h8003});
        chk("absx_op", {opcode, imm}, {8'hBD, 8'h0F});
        tick; chk("hold_frozen", {instr_valid, mem_rd, eff_addr}, {1'b1, 1'b0, 16'h1300});
        instr_ack = 1'b1;
        tick; chk("ack_next_opc", {instr_valid, mem_rd, mem_addr}, {1'b0, 1'b1, 16'h8003});
        instr_ack = 1'b0;

        // LDA (zp),Y
        r_mem[16'h8000] = 8'hB1; r_mem[16'h8001] = 8'h20;
        r_mem[16'h0020] = 8'hFF; r_mem[16'h0021] = 8'h10;
        y_in = 8'h01;
        boot(16'h8000);
        tick; tick; chk("indy_ptr_lo", {mem_rd, mem_addr}, {1'b1, 16'h0020});
        tick; chk("indy_ptr_hi", {mem_rd, mem_addr}, {1'b1, 16'h0021});
        wait_valid(lat);
        chk("indy_lat", lat, 2);
        chk("indy_mode", add_mode, 4'd9);
        chk("indy_ea", {page_cross, eff_addr}, {1'b1, 16'h1100});

        // JMP (ind) across a page boundary
        r_mem[16'h8000] = 8'h6C; r_mem[16'h8001] = 8'hFF; r_mem[16'h8002] = 8'h30;
        r_mem[16'h30FF] = 8'h40; r_mem[16'h3000] = 8'h50; r_mem[16'h3100] = 8'h60;
        boot(16'h8000);
        wait_valid(lat);
        chk("ind_lat", lat, 6);
        chk("ind_mode", add_mode, 4'd10);
        chk("ind_ea", eff_addr, r_exp_ind);

        // BNE forward across a page, without and with wait states
        r_mem[16'h80FD] = 8'hD0; r_mem[16'h80FE] = 8'h05;
        boot(16'h80FD);
        wait_valid(lat);
        chk("rel_lat", lat, 3);
        chk("rel_mode", {add_mode, imm}, {4'd11, 8'h05});
        chk("rel_ea", {page_cross, eff_addr, pc}, {1'b1, 16'h8104, 16'h80FF});
        boot(16'h80FD);
        tick; chk("rel_op1_rd", {mem_rd, mem_addr}, {1'b1, 16'h80FE});
        mem_ready = 1'b0;
        tick; tick; tick;
        chk("rel_wait_stable", {mem_rd, mem_addr, instr_valid}, {1'b1, 16'h80FE, 1'b0});
        mem_ready = 1'b1;
        wait_valid(lat);
        chk("rel_wait_lat", lat + 4, 6);
        chk("rel_wait_ea", {page_cross, eff_addr}, {1'b1, 16'h8104});

        // Redirect during the OP2 wait of an ABS fetch
        r_mem[16'h8000] = 8'hAD; r_mem[16'h8001] = 8'h34; r_mem[16'h8002] = 8'h12;
        r_mem[16'h9000] = 8'hEA;
        boot(16'h8000);
        tick; tick; chk("abs_op2_rd", {mem_rd, mem_addr}, {1'b1, 16'h8002});
        mem_ready = 1'b0;
        tick;
        pc_load = 1'b1; pc_load_val = 16'h9000;
        tick; chk("load_drop", {mem_rd, instr_valid, pc}, {1'b0, 1'b0, 16'h9000});
        pc_load = 1'b0; mem_ready = 1'b1;
        tick; chk("load_reissue", {mem_rd, mem_addr, instr_valid}, {1'b1, 16'h9000, 1'b0});
        wait_valid(lat);
        chk("nop_lat", lat, 2);
        chk("nop_fields", {add_mode, opcode, instr_pc, pc}, {4'd0, 8'hEA, 16'h9000, 16'h9001});

        // pc_load beats a simultaneous instr_ack; then LDX zp,Y with wrap
        r_mem[16'hA000] = 8'hB6; r_mem[16'hA001] = 8'h80;
        y_in = 8'h90;
        instr_ack = 1'b1; pc_load = 1'b1; pc_load_val = 16'hA000;
        tick; chk("load_vs_ack", {mem_rd, instr_valid, pc}, {1'b0, 1'b0, 16'hA000});
        instr_ack = 1'b0; pc_load = 1'b0;
        tick; chk("load2_reissue", {mem_rd, mem_addr}, {1'b1, 16'hA000});
        wait_valid(lat);
        chk("zpy_lat", lat, 3);
        chk("zpy_ea", {add_mode, page_cross, eff_addr, pc}, {4'd4, 1'b0, 16'h0010, 16'hA002});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
